// File: rtl/store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_buffer_pkg
// Shared CPU definitions used by the store buffer and the data memory:
//   - load/store width encodings (LS_WORD / LS_HALF / LS_BYTE)
//   - default number of pending-store entries
//   - the record kept for every pending store
// ---------------------------------------------------------------------------
package store_buffer_pkg;

  // Default store-buffer depth (power of two, 2..16)
  localparam int DEFAULT_DEPTH = 4;

  // Memory access width, same encoding the data memory decodes
  typedef enum logic [2:0] {
    LS_WORD = 3'b000,
    LS_HALF = 3'b001,
    LS_BYTE = 3'b010
  } ls_type_e;

  // One pending store; lstype kept as raw bits so it can be forwarded untouched
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  lstype;
    logic [31:0] pc;
  } sb_entry_t;

  // Word index used for load/store hazard detection
  localparam int HAZ_LSB = 2;
  localparam int HAZ_MSB = 11;
  localparam int HAZ_W   = HAZ_MSB - HAZ_LSB + 1;

endpackage

// File: rtl/store_buffer_if.sv
// ---------------------------------------------------------------------------
// store_buffer_if
// Bundles the MEM-stage store/load request signals and the data-memory write
// command produced by the store buffer.
//   master : pipeline side (drives st_*, ld_*; observes ready/stall/dm_*)
//   slave  : store buffer side
// Signals:
//   st_valid/st_addr/st_data/st_type/st_pc  store request
//   st_ready                                 buffer can accept a store
//   ld_valid/ld_addr                         load using the DM port
//   ld_stall                                 load hits a pending store
//   dm_we/dm_addr/dm_wd/dm_lstype/dm_pc      DM write command (head entry)
//   count/empty                              occupancy
// ---------------------------------------------------------------------------
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_type;
  logic [31:0]   st_pc;
  logic          st_ready;

  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_stall;

  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wd;
  logic [2:0]    dm_lstype;
  logic [31:0]   dm_pc;

  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data, st_type, st_pc,
    output ld_valid, ld_addr,
    input  st_ready, ld_stall,
    input  dm_we, dm_addr, dm_wd, dm_lstype, dm_pc,
    input  count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_type, st_pc,
    input  ld_valid, ld_addr,
    output st_ready, ld_stall,
    output dm_we, dm_addr, dm_wd, dm_lstype, dm_pc,
    output count, empty
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// ---------------------------------------------------------------------------
// store_buffer_fifo
// Circular FIFO of pending stores: entry storage, head/tail pointers and the
// occupancy count. Also exposes which slots are live and the word index of
// every slot so the parent can do the load hazard compare.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   enq, enq_entry   push enq_entry at tail (ignored when full)
//   deq              pop head (ignored when empty)
//   head_entry       entry at head (meaningful only when !empty)
//   count, empty     occupancy
//   slot_valid       per-slot live flag
//   slot_word        per-slot addr[11:2]
// ---------------------------------------------------------------------------
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enq,
  input  sb_entry_t                   enq_entry,
  input  logic                        deq,
  output sb_entry_t                   head_entry,
  output logic [CW-1:0]               count,
  output logic                        empty,
  output logic [DEPTH-1:0]            slot_valid,
  output logic [DEPTH-1:0][HAZ_W-1:0] slot_word
);

  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          enq_ok;
  logic          deq_ok;

  // Guards keep count inside 0..DEPTH even if a caller misbehaves
  assign enq_ok = enq && (count != CW'(DEPTH));
  assign deq_ok = deq && (count != '0);
  assign empty  = (count == '0);

  // Pointers and count; pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_ok) tail <= tail + 1'b1;
      if (deq_ok) head <= head + 1'b1;
      case ({enq_ok, deq_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; only live slots are ever looked at
  always_ff @(posedge clk) begin
    if (enq_ok) mem[tail] <= enq_entry;
  end

  assign head_entry = mem[head];

  // A slot is live when its distance from head is below the occupancy
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      logic [PW-1:0] offset;
      assign offset        = PW'(g) - head;
      assign slot_valid[g] = ({1'b0, offset} < count);
      assign slot_word[g]  = mem[g].addr[HAZ_MSB:HAZ_LSB];
    end
  endgenerate

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Decouples MEM-stage stores from the single data-memory port. Stores are
// queued and written from the head whenever the port is free; a load that
// touches the same word as any pending store stalls until it drains.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous active-low reset
//   bus    store_buffer_if.slave (store/load requests, DM write command,
//          occupancy)
// ---------------------------------------------------------------------------
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t                   enq_entry;
  sb_entry_t                   head_entry;
  logic                        enq;
  logic                        deq;
  logic                        empty;
  logic [CW-1:0]               count;
  logic [DEPTH-1:0]            slot_valid;
  logic [DEPTH-1:0]            slot_hit;
  logic [DEPTH-1:0][HAZ_W-1:0] slot_word;
  logic                        st_ready;
  logic                        ld_stall;
  logic                        unused_ld_bits;

  store_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq        (enq),
    .enq_entry  (enq_entry),
    .deq        (deq),
    .head_entry (head_entry),
    .count      (count),
    .empty      (empty),
    .slot_valid (slot_valid),
    .slot_word  (slot_word)
  );

  assign enq_entry = '{addr:   bus.st_addr,
                       data:   bus.st_data,
                       lstype: bus.st_type,
                       pc:     bus.st_pc};

  // Ready comes only from the registered count, so no st_valid/dm_we loop
  assign st_ready = (count < CW'(DEPTH));
  assign enq      = bus.st_valid && st_ready;

  // Word-granular hazard compare against every live entry
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_hit
      assign slot_hit[g] = slot_valid[g] &&
                           (slot_word[g] == bus.ld_addr[HAZ_MSB:HAZ_LSB]);
    end
  endgenerate

  assign ld_stall = bus.ld_valid && (|slot_hit);

  // Loads own the port, except when they are stalled on us: then we must
  // drain or the pipeline would wait forever
  assign deq = !empty && (!bus.ld_valid || ld_stall);

  // DM command shows the head entry, forced to zero when nothing is pending
  always_comb begin
    bus.dm_addr   = '0;
    bus.dm_wd     = '0;
    bus.dm_lstype = '0;
    bus.dm_pc     = '0;
    if (!empty) begin
      bus.dm_addr   = head_entry.addr;
      bus.dm_wd     = head_entry.data;
      bus.dm_lstype = head_entry.lstype;
      bus.dm_pc     = head_entry.pc;
    end
  end

  assign bus.dm_we    = deq;
  assign bus.st_ready = st_ready;
  assign bus.ld_stall = ld_stall;
  assign bus.count    = count;
  assign bus.empty    = empty;

  // Load address bits outside the compared word index are intentionally ignored
  assign unused_ld_bits = ^{bus.ld_addr[31:HAZ_MSB+1], bus.ld_addr[HAZ_LSB-1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
// Directed self-checking bench for store_buffer (DEPTH = 4). Inputs change
// 1 ns after a rising edge, outputs are checked 1 ns later, well away from
// the next edge.
// ---------------------------------------------------------------------------
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  store_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's worth of inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic        stv,
                               input logic [31:0] sta,
                               input logic [31:0] std,
                               input logic [2:0]  stt,
                               input logic [31:0] stp,
                               input logic        ldv,
                               input logic [31:0] lda);
    bus.st_valid = stv;
    bus.st_addr  = sta;
    bus.st_data  = std;
    bus.st_type  = stt;
    bus.st_pc    = stp;
    bus.ld_valid = ldv;
    bus.ld_addr  = lda;
    #1;
  endtask

  task automatic idle(input logic ldv, input logic [31:0] lda);
    applyStimulus(1'b0, 32'h0, 32'h0, LS_WORD, 32'h0, ldv, lda);
  endtask

  task automatic checkOutput(input string tag,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Move to 1 ns after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b0;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_type  = LS_WORD;
    bus.st_pc    = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    #2;

    // ---- reset state ----
    checkOutput("rst_st_ready", 32'(bus.st_ready), 32'd1);
    checkOutput("rst_empty",    32'(bus.empty),    32'd1);
    checkOutput("rst_count",    32'(bus.count),    32'd0);
    checkOutput("rst_dm_we",    32'(bus.dm_we),    32'd0);
    checkOutput("rst_ld_stall", 32'(bus.ld_stall), 32'd0);
    checkOutput("rst_dm_addr",  bus.dm_addr,       32'h0);
    checkOutput("rst_dm_wd",    bus.dm_wd,         32'h0);
    nextCycle();
    reset = 1'b1;

    // ---- single word store, written the cycle after acceptance ----
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, LS_WORD, 32'h3000, 1'b0, 32'h0);
    checkOutput("t1_no_bypass", 32'(bus.dm_we), 32'd0);
    nextCycle();
    idle(1'b0, 32'h0);
    checkOutput("t1_dm_we",     32'(bus.dm_we),     32'd1);
    checkOutput("t1_dm_addr",   bus.dm_addr,        32'h10);
    checkOutput("t1_dm_wd",     bus.dm_wd,          32'hDEADBEEF);
    checkOutput("t1_dm_lstype", 32'(bus.dm_lstype), 32'(LS_WORD));
    checkOutput("t1_dm_pc",     bus.dm_pc,          32'h3000);
    checkOutput("t1_count",     32'(bus.count),     32'd1);
    nextCycle();
    idle(1'b0, 32'h0);
    checkOutput("t1_empty",     32'(bus.empty),     32'd1);
    checkOutput("t1_dm_we_off", 32'(bus.dm_we),     32'd0);
    checkOutput("t1_addr_zero", bus.dm_addr,        32'h0);

    // ---- fill under non-conflicting loads, 5th ignored, drain in order ----
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), LS_WORD,
                    32'h4000 + 32'(4 * i), 1'b1, 32'h800);
      checkOutput("t2_fill_dm_we", 32'(bus.dm_we),    32'd0);
      checkOutput("t2_fill_stall", 32'(bus.ld_stall), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h200, 32'hBAD0BAD0, LS_WORD, 32'h4010, 1'b1, 32'h800);
    checkOutput("t2_count_full", 32'(bus.count),    32'd4);
    checkOutput("t2_not_ready",  32'(bus.st_ready), 32'd0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      idle(1'b0, 32'h0);
      checkOutput("t2_drain_count", 32'(bus.count), 32'(4 - k));
      checkOutput("t2_drain_we",    32'(bus.dm_we), 32'd1);
      checkOutput("t2_drain_addr",  bus.dm_addr,    32'h100 + 32'(4 * k));
      checkOutput("t2_drain_wd",    bus.dm_wd,      32'hA000_0000 + 32'(k));
      nextCycle();
    end
    idle(1'b0, 32'h0);
    checkOutput("t2_empty", 32'(bus.empty), 32'd1);

    // ---- hazard: bits above 11 ignored, different word does not stall ----
    applyStimulus(1'b1, 32'h1022, 32'h1234, LS_HALF, 32'h5000, 1'b0, 32'h0);
    nextCycle();
    idle(1'b1, 32'h24);
    checkOutput("t3_other_word_stall", 32'(bus.ld_stall), 32'd0);
    checkOutput("t3_load_owns_port",   32'(bus.dm_we),    32'd0);
    nextCycle();
    idle(1'b1, 32'h20);
    checkOutput("t3_alias_stall", 32'(bus.ld_stall), 32'd1);
    checkOutput("t3_alias_we",    32'(bus.dm_we),    32'd1);
    checkOutput("t3_alias_addr",  bus.dm_addr,       32'h1022);
    checkOutput("t3_alias_type",  32'(bus.dm_lstype), 32'(LS_HALF));
    nextCycle();

    // ---- hazard: byte store 0x23 vs load 0x20 ----
    applyStimulus(1'b1, 32'h23, 32'hAB, LS_BYTE, 32'h3100, 1'b0, 32'h0);
    nextCycle();
    idle(1'b1, 32'h20);
    checkOutput("t3_byte_stall",  32'(bus.ld_stall),  32'd1);
    checkOutput("t3_byte_we",     32'(bus.dm_we),     32'd1);
    checkOutput("t3_byte_addr",   bus.dm_addr,        32'h23);
    checkOutput("t3_byte_type",   32'(bus.dm_lstype), 32'(LS_BYTE));
    nextCycle();
    idle(1'b1, 32'h20);
    checkOutput("t3_stall_clear", 32'(bus.ld_stall), 32'd0);
    checkOutput("t3_empty",       32'(bus.empty),    32'd1);

    // ---- full buffer: store in draining cycle rejected, next accepted ----
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), LS_WORD,
                    32'h6000, 1'b1, 32'h800);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h3F0, 32'hBAD1BAD1, LS_WORD, 32'h6000, 1'b0, 32'h0);
    checkOutput("t4_full_ready", 32'(bus.st_ready), 32'd0);
    checkOutput("t4_drain_we",   32'(bus.dm_we),    32'd1);
    checkOutput("t4_drain_addr", bus.dm_addr,       32'h300);
    nextCycle();
    applyStimulus(1'b1, 32'h310, 32'hC0000004, LS_WORD, 32'h6000, 1'b1, 32'h800);
    checkOutput("t4_ready_after", 32'(bus.st_ready), 32'd1);
    checkOutput("t4_count_3",     32'(bus.count),    32'd3);
    nextCycle();
    idle(1'b0, 32'h0);
    checkOutput("t4_count_4",     32'(bus.count),    32'd4);
    for (int k = 1; k < 5; k++) begin
      if (k > 1) idle(1'b0, 32'h0);
      checkOutput("t4_order_addr", bus.dm_addr, 32'h300 + 32'(4 * k));
      checkOutput("t4_order_we",   32'(bus.dm_we), 32'd1);
      nextCycle();
    end
    idle(1'b0, 32'h0);
    checkOutput("t4_empty", 32'(bus.empty), 32'd1);

    // ---- reset mid-drain discards everything ----
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'hD000_0000 + 32'(i), LS_WORD,
                    32'h7000, 1'b1, 32'h800);
      nextCycle();
    end
    idle(1'b0, 32'h0);
    checkOutput("t5_first_addr", bus.dm_addr,    32'h400);
    checkOutput("t5_count3",     32'(bus.count), 32'd3);
    nextCycle();
    idle(1'b0, 32'h0);
    checkOutput("t5_second_addr", bus.dm_addr, 32'h404);
    reset = 1'b0;
    #1;
    checkOutput("t5_rst_we",    32'(bus.dm_we),    32'd0);
    checkOutput("t5_rst_count", 32'(bus.count),    32'd0);
    checkOutput("t5_rst_ready", 32'(bus.st_ready), 32'd1);
    checkOutput("t5_rst_addr",  bus.dm_addr,       32'h0);
    nextCycle();
    checkOutput("t5_hold_we", 32'(bus.dm_we), 32'd0);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("t5_post_we",    32'(bus.dm_we), 32'd0);
      checkOutput("t5_post_empty", 32'(bus.empty), 32'd1);
    end

    // ---- pointer wrap: 10 streaming stores, each written one cycle later ----
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), 32'hE000_0000 + 32'(i), LS_WORD,
                    32'h8000 + 32'(4 * i), 1'b0, 32'h0);
      if (i == 0) begin
        checkOutput("t6_first_we", 32'(bus.dm_we), 32'd0);
      end else begin
        checkOutput("t6_wrap_we",   32'(bus.dm_we), 32'd1);
        checkOutput("t6_wrap_addr", bus.dm_addr,    32'h500 + 32'(4 * (i - 1)));
        checkOutput("t6_wrap_pc",   bus.dm_pc,      32'h8000 + 32'(4 * (i - 1)));
      end
      nextCycle();
    end
    idle(1'b0, 32'h0);
    checkOutput("t6_last_addr", bus.dm_addr, 32'h524);
    checkOutput("t6_last_wd",   bus.dm_wd,   32'hE0000009);
    nextCycle();
    checkOutput("t6_empty", 32'(bus.empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
